// File: rtl/recepcao_serial_pedidos_pkg.sv
// Shared types and constants for the serial pedido receiver: frame header,
// parser/UART state encodings, error codes and the pedido record.
package pedidos_pkg;

  localparam logic [7:0] CABECALHO_PADRAO = 8'hA5;

  typedef enum logic [1:0] {
    ESPERA_CAB  = 2'd0,
    ESPERA_DADO = 2'd1,
    ESPERA_CHK  = 2'd2,
    VALIDA      = 2'd3
  } estado_parser_t;

  typedef enum logic [2:0] {
    UART_IDLE     = 3'd0,
    UART_START    = 3'd1,
    UART_DADOS    = 3'd2,
    UART_PARIDADE = 3'd3,
    UART_STOP     = 3'd4
  } estado_uart_t;

  localparam logic [2:0] ERR_NENHUM     = 3'b000;
  localparam logic [2:0] ERR_FRAMING    = 3'b001;
  localparam logic [2:0] ERR_CHECKSUM   = 3'b010;
  localparam logic [2:0] ERR_FORMATO    = 3'b011;
  localparam logic [2:0] ERR_FILA_CHEIA = 3'b100;
  localparam logic [2:0] ERR_TIMEOUT    = 3'b101;
  localparam logic [2:0] ERR_PARIDADE   = 3'b110;

  typedef struct packed {
    logic [1:0] tipo;
    logic [1:0] origem;
    logic [1:0] destino;
  } pedido_t;

  // Payload layout is {2'b00, tipo, origem, destino}.
  function automatic pedido_t desempacota(input logic [7:0] payload);
    pedido_t p;
    p.tipo    = payload[5:4];
    p.origem  = payload[3:2];
    p.destino = payload[1:0];
    return p;
  endfunction

  // A payload is well formed when the spare bits are zero and the trip is not to the same floor.
  function automatic logic formato_ok(input logic [7:0] payload);
    return (payload[7:6] == 2'b00) && (payload[3:2] != payload[1:0]);
  endfunction

endpackage

// File: rtl/recepcao_serial_pedidos_uart_rx.sv
// UART receiver for the pedido link: 2-FF synchronizer, baud/bit counters,
// mid-bit sampling. Build option PARIDADE_EN selects 8E1 (otherwise 8N1).
// All outputs are registered 1-cycle pulses except dado, which holds the last good byte.
module uart_rx_serial
  import pedidos_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       RX,
  output logic       byte_ok,
  output logic [7:0] dado,
  output logic       erro_framing,
  output logic       erro_paridade
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
  localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MEIO = CW'(CLKS_PER_BIT / 2 - 1);

  logic         rx_s1_q, rx_s2_q, rx_ant_q;
  estado_uart_t estado_q, estado_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]   bit_q, bit_d;
  logic [7:0]   shreg_q, shreg_d;
  logic         par_err_q, par_err_d;
  logic         byte_ok_q, byte_ok_d;
  logic [7:0]   dado_q, dado_d;
  logic         ferr_q, ferr_d;
  logic         perr_q, perr_d;
  logic         queda;

  assign queda = rx_ant_q & ~rx_s2_q;

  // Synchronizer stages idle high so reset never looks like a start bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_s1_q  <= 1'b1;
      rx_s2_q  <= 1'b1;
      rx_ant_q <= 1'b1;
    end else begin
      rx_s1_q  <= RX;
      rx_s2_q  <= rx_s1_q;
      rx_ant_q <= rx_s2_q;
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q  <= UART_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      par_err_q <= 1'b0;
      byte_ok_q <= 1'b0;
      dado_q    <= '0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      par_err_q <= par_err_d;
      byte_ok_q <= byte_ok_d;
      dado_q    <= dado_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
    end
  end

  // Bit timing: start re-check at half a bit, then one sample per bit period (mid-bit).
  always_comb begin
    estado_d  = estado_q;
    cnt_d     = cnt_q + 1'b1;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    par_err_d = par_err_q;
    byte_ok_d = 1'b0;
    dado_d    = dado_q;
    ferr_d    = 1'b0;
    perr_d    = 1'b0;
    case (estado_q)
      UART_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (queda) begin
          estado_d  = UART_START;
          par_err_d = 1'b0;
        end
      end
      UART_START: begin
        if (cnt_q == CNT_MEIO) begin
          cnt_d    = '0;
          estado_d = rx_s2_q ? UART_IDLE : UART_DADOS;
        end
      end
      UART_DADOS: begin
        if (cnt_q == CNT_BIT) begin
          cnt_d   = '0;
          shreg_d = {rx_s2_q, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef PARIDADE_EN
            estado_d = UART_PARIDADE;
`else
            estado_d = UART_STOP;
`endif
          end
        end
      end
      UART_PARIDADE: begin
        if (cnt_q == CNT_BIT) begin
          cnt_d     = '0;
          par_err_d = ^{shreg_q, rx_s2_q};
          estado_d  = UART_STOP;
        end
      end
      UART_STOP: begin
        if (cnt_q == CNT_BIT) begin
          cnt_d    = '0;
          estado_d = UART_IDLE;
          if (!rx_s2_q) begin
            ferr_d = 1'b1;
          end else if (par_err_q) begin
            perr_d = 1'b1;
          end else begin
            byte_ok_d = 1'b1;
            dado_d    = shreg_q;
          end
        end
      end
      default: estado_d = UART_IDLE;
    endcase
  end

  assign byte_ok       = byte_ok_q;
  assign dado          = dado_q;
  assign erro_framing  = ferr_q;
  assign erro_paridade = perr_q;

endmodule

// File: rtl/recepcao_serial_pedidos.sv
// Serial pedido receiver: UART front end plus a 3-byte frame parser
// (header, payload, checksum) that issues one write strobe per valid pedido.
// Parity checking in the UART is enabled by defining PARIDADE_EN.
module recepcao_serial_pedidos
  import pedidos_pkg::*;
#(
  parameter int         CLKS_PER_BIT   = 434,
  parameter int         TIMEOUT_CICLOS = 20 * CLKS_PER_BIT,
  parameter logic [7:0] CABECALHO      = CABECALHO_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       RX,
  input  logic       fila_cheia,
  output logic [1:0] in_tipo_objeto,
  output logic [1:0] in_origem_objeto,
  output logic [1:0] in_destino_objeto,
  output logic       weT,
  output logic       erro_pedido,
  output logic [2:0] codigo_erro,
  output logic [7:0] pedidos_aceitos
);

  localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
  localparam logic [TW-1:0] GAP_LIMITE = TW'(TIMEOUT_CICLOS - 1);

  logic       byte_ok, erro_framing, erro_paridade;
  logic [7:0] dado;

  uart_rx_serial #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clock        (clock),
    .reset        (reset),
    .RX           (RX),
    .byte_ok      (byte_ok),
    .dado         (dado),
    .erro_framing (erro_framing),
    .erro_paridade(erro_paridade)
  );

  estado_parser_t estado_q, estado_d;
  logic [7:0]     payload_q, payload_d;
  logic [TW-1:0]  gap_q, gap_d;
  pedido_t        pedido_q, pedido_d;
  logic           weT_q, weT_d;
  logic           erro_q, erro_d;
  logic [2:0]     codigo_q, codigo_d;
  logic [7:0]     aceitos_q, aceitos_d;

  // Parser state, timeout counter and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q  <= ESPERA_CAB;
      payload_q <= '0;
      gap_q     <= '0;
      pedido_q  <= '0;
      weT_q     <= 1'b0;
      erro_q    <= 1'b0;
      codigo_q  <= ERR_NENHUM;
      aceitos_q <= '0;
    end else begin
      estado_q  <= estado_d;
      payload_q <= payload_d;
      gap_q     <= gap_d;
      pedido_q  <= pedido_d;
      weT_q     <= weT_d;
      erro_q    <= erro_d;
      codigo_q  <= codigo_d;
      aceitos_q <= aceitos_d;
    end
  end

  // Next state. The validation verdict is registered on the checksum byte_ok,
  // so weT, in_* and the counter all change in the single VALIDA cycle.
  always_comb begin
    estado_d  = estado_q;
    payload_d = payload_q;
    pedido_d  = pedido_q;
    weT_d     = 1'b0;
    erro_d    = 1'b0;
    codigo_d  = codigo_q;
    aceitos_d = aceitos_q;

    if ((estado_q == ESPERA_DADO || estado_q == ESPERA_CHK) && !byte_ok) begin
      gap_d = gap_q + 1'b1;
    end else begin
      gap_d = '0;
    end

    if (erro_framing) begin
      erro_d   = 1'b1;
      codigo_d = ERR_FRAMING;
      estado_d = ESPERA_CAB;
    end else if (erro_paridade) begin
      erro_d   = 1'b1;
      codigo_d = ERR_PARIDADE;
      estado_d = ESPERA_CAB;
    end else begin
      case (estado_q)
        ESPERA_CAB: begin
          if (byte_ok && dado == CABECALHO) estado_d = ESPERA_DADO;
        end
        ESPERA_DADO: begin
          if (byte_ok) begin
            payload_d = dado;
            estado_d  = ESPERA_CHK;
          end else if (gap_q == GAP_LIMITE) begin
            erro_d   = 1'b1;
            codigo_d = ERR_TIMEOUT;
            estado_d = ESPERA_CAB;
          end
        end
        ESPERA_CHK: begin
          if (byte_ok) begin
            estado_d = VALIDA;
            if (dado != (CABECALHO ^ payload_q)) begin
              erro_d   = 1'b1;
              codigo_d = ERR_CHECKSUM;
            end else if (!formato_ok(payload_q)) begin
              erro_d   = 1'b1;
              codigo_d = ERR_FORMATO;
            end else if (fila_cheia) begin
              erro_d   = 1'b1;
              codigo_d = ERR_FILA_CHEIA;
            end else begin
              weT_d    = 1'b1;
              pedido_d = desempacota(payload_q);
              if (aceitos_q != 8'hFF) aceitos_d = aceitos_q + 8'd1;
            end
          end else if (gap_q == GAP_LIMITE) begin
            erro_d   = 1'b1;
            codigo_d = ERR_TIMEOUT;
            estado_d = ESPERA_CAB;
          end
        end
        VALIDA: estado_d = ESPERA_CAB;
        default: estado_d = ESPERA_CAB;
      endcase
    end
  end

  assign in_tipo_objeto    = pedido_q.tipo;
  assign in_origem_objeto  = pedido_q.origem;
  assign in_destino_objeto = pedido_q.destino;
  assign weT               = weT_q;
  assign erro_pedido       = erro_q;
  assign codigo_erro       = codigo_q;
  assign pedidos_aceitos   = aceitos_q;

endmodule

// File: tb/tb_recepcao_serial_pedidos.sv
// Bench for recepcao_serial_pedidos: UART frames driven on RX, expected
// accept/reject events queued at stimulus time and compared as they appear.
module tb_recepcao_serial_pedidos;
  import pedidos_pkg::*;

  localparam int CPB = 8;
  localparam int TMO = 20 * CPB;
  localparam int GAP = 4;

  logic       clock = 1'b0;
  logic       reset, RX, fila_cheia;
  logic [1:0] in_tipo_objeto, in_origem_objeto, in_destino_objeto;
  logic       weT, erro_pedido;
  logic [2:0] codigo_erro;
  logic [7:0] pedidos_aceitos;

  always #5 clock = ~clock;

  recepcao_serial_pedidos #(
    .CLKS_PER_BIT  (CPB),
    .TIMEOUT_CICLOS(TMO),
    .CABECALHO     (8'hA5)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .RX               (RX),
    .fila_cheia       (fila_cheia),
    .in_tipo_objeto   (in_tipo_objeto),
    .in_origem_objeto (in_origem_objeto),
    .in_destino_objeto(in_destino_objeto),
    .weT              (weT),
    .erro_pedido      (erro_pedido),
    .codigo_erro      (codigo_erro),
    .pedidos_aceitos  (pedidos_aceitos)
  );

  typedef struct {
    logic       aceito;
    logic [2:0] codigo;
    logic [5:0] pedido;
    logic [7:0] cnt;
  } evento_t;

  evento_t    esperados[$];
  evento_t    ev_mon;
  logic [7:0] m_cnt;
  logic [5:0] m_ped;
  logic [2:0] m_cod;
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 8'd0;
    m_ped = 6'd0;
    m_cod = 3'd0;
  endtask

  task automatic push_aceito(input logic [5:0] p);
    evento_t e;
    m_cnt    = (m_cnt == 8'hFF) ? 8'hFF : m_cnt + 8'd1;
    m_ped    = p;
    e.aceito = 1'b1;
    e.codigo = m_cod;
    e.pedido = m_ped;
    e.cnt    = m_cnt;
    esperados.push_back(e);
  endtask

  task automatic push_erro(input logic [2:0] c);
    evento_t e;
    m_cod    = c;
    e.aceito = 1'b0;
    e.codigo = m_cod;
    e.pedido = m_ped;
    e.cnt    = m_cnt;
    esperados.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v = 1'b1, input logic par_flip = 1'b0);
    RX = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (CPB) @(negedge clock);
    end
`ifdef PARIDADE_EN
    RX = (^b) ^ par_flip;
    repeat (CPB) @(negedge clock);
`else
    if (par_flip) RX = 1'b1;
`endif
    RX = stop_v;
    repeat (CPB) @(negedge clock);
    RX = 1'b1;
    repeat (GAP) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
  endtask

  task automatic drenar(input int limite);
    int k = 0;
    while (esperados.size() != 0 && k < limite) begin
      @(negedge clock);
      k++;
    end
    repeat (4) @(negedge clock);
    check_val("fila_esperados", esperados.size(), 0);
    esperados.delete();
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_tipo"}, in_tipo_objeto, 0);
    check_val({tag, "_origem"}, in_origem_objeto, 0);
    check_val({tag, "_destino"}, in_destino_objeto, 0);
    check_val({tag, "_weT"}, weT, 0);
    check_val({tag, "_erro"}, erro_pedido, 0);
    check_val({tag, "_codigo"}, codigo_erro, 0);
    check_val({tag, "_aceitos"}, pedidos_aceitos, 0);
  endtask

  // Every weT or erro_pedido cycle must match the next queued expectation.
  always @(negedge clock) begin
    if (reset === 1'b0 && (weT === 1'b1 || erro_pedido === 1'b1)) begin
      if (esperados.size() == 0) begin
        check_val("evento_sem_esperado", {weT, erro_pedido}, 2'b00);
      end else begin
        ev_mon = esperados.pop_front();
        check_val("weT", weT, ev_mon.aceito);
        check_val("erro_pedido", erro_pedido, !ev_mon.aceito);
        check_val("codigo_erro", codigo_erro, ev_mon.codigo);
        check_val("pedido", {in_tipo_objeto, in_origem_objeto, in_destino_objeto}, ev_mon.pedido);
        check_val("pedidos_aceitos", pedidos_aceitos, ev_mon.cnt);
      end
    end
  end

  initial begin
    logic [1:0] t, o, d;
    reset      = 1'b1;
    RX         = 1'b1;
    fila_cheia = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    check_zero("reset");
    reset = 1'b0;
    repeat (5) @(negedge clock);
    check_zero("pos_reset");

    // Basic accepted frame
    push_aceito(6'b01_10_11);
    send_frame(8'hA5, 8'h1B, 8'hBE);
    drenar(100);

    // Bad checksum
    push_erro(ERR_CHECKSUM);
    send_frame(8'hA5, 8'h1B, 8'h00);
    drenar(100);

    // origem == destino, then a good frame
    push_erro(ERR_FORMATO);
    send_frame(8'hA5, 8'h15, 8'hB0);
    push_aceito(6'b01_10_11);
    send_frame(8'hA5, 8'h1B, 8'hBE);
    drenar(100);

    // Non-zero spare bits in the payload
    push_erro(ERR_FORMATO);
    send_frame(8'hA5, 8'h5B, 8'hFE);
    drenar(100);

    // Header value as payload is data, not a resync (A5^A5 = 00; spare bits set)
    push_erro(ERR_FORMATO);
    send_frame(8'hA5, 8'hA5, 8'h00);
    drenar(100);

    // Fila cheia
    fila_cheia = 1'b1;
    push_erro(ERR_FILA_CHEIA);
    send_frame(8'hA5, 8'h1B, 8'hBE);
    drenar(100);
    fila_cheia = 1'b0;

    // Garbage before the header is ignored; different pedido pattern
    push_aceito(6'b10_00_01);
    send_byte(8'h3C);
    send_frame(8'hA5, 8'h21, 8'h84);
    drenar(100);

    // Timeout after the header
    push_erro(ERR_TIMEOUT);
    send_byte(8'hA5);
    drenar(TMO + 200);
    push_aceito(6'b01_10_11);
    send_frame(8'hA5, 8'h1B, 8'hBE);
    drenar(100);

    // Reset mid-payload
    send_byte(8'hA5);
    RX = 1'b0;
    repeat (4 * CPB) @(negedge clock);
    reset = 1'b1;
    #1;
    check_zero("reset_meio");
    RX = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();
    repeat (3 * CPB) @(negedge clock);
    push_aceito(6'b01_10_11);
    send_frame(8'hA5, 8'h1B, 8'hBE);
    drenar(100);

    // Framing error on the payload byte; the trailing byte is not a header
    push_erro(ERR_FRAMING);
    send_byte(8'hA5);
    send_byte(8'h1B, 1'b0);
    send_byte(8'hBE);
    drenar(100);

`ifdef PARIDADE_EN
    push_erro(ERR_PARIDADE);
    send_byte(8'hA5);
    send_byte(8'h1B, 1'b1, 1'b1);
    drenar(100);
`endif

    // Saturation: 256 valid frames from a cleared counter
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    repeat (4) @(negedge clock);
    for (int n = 0; n < 256; n++) begin
      t = 2'($urandom_range(0, 3));
      o = 2'($urandom_range(0, 3));
      d = o + 2'($urandom_range(1, 3));
      push_aceito({t, o, d});
      send_frame(8'hA5, {2'b00, t, o, d}, 8'hA5 ^ {2'b00, t, o, d});
    end
    drenar(100);
    check_val("satura", pedidos_aceitos, 8'd255);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
